// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the decoded key outputs.
//   rows      keypad row lines, active-low (pulled up off-chip)
//   cols      keypad column drive, active-low, one bit low at a time
//   key       hex code of the last accepted key
//   key_valid one-cycle strobe, key is new on this cycle
//   key_held  accepted key not yet debounced as released
//   value     last four accepted codes, newest in [3:0]
// master: the scanner side; slave: the keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] value;

  modport master (
    input  rows,
    output cols,
    output key,
    output key_valid,
    output key_held,
    output value
  );

  modport slave (
    output rows,
    input  cols,
    input  key,
    input  key_valid,
    input  key_held,
    input  value
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex matrix keypad scanner with frame-based debounce.
// Drives one column low at a time, samples the synchronized rows at the end
// of each column dwell, classifies each full frame as NONE / KEY / MULTI and
// accepts a press or a release after DEBOUNCE_FRAMES identical frames.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   kp   keypad_scanner_if.master (rows in; cols, key, key_valid,
//        key_held, value out)
module keypad_scanner #(
  parameter int SCAN_DIV_W      = 12,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp
);

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } res_kind_t;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  localparam logic [3:0]            DEB     = DEBOUNCE_FRAMES[3:0];
  localparam logic [SCAN_DIV_W-1:0] CNT_ONE = {{(SCAN_DIV_W-1){1'b0}}, 1'b1};

  // Number of active (low) row lines in one column sample.
  function automatic logic [2:0] hit_count(input logic [3:0] rows_n);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, ~rows_n[i]};
    end
    return n;
  endfunction

  // Index of the lowest active row; only meaningful when exactly one is low.
  function automatic logic [1:0] first_row(input logic [3:0] rows_n);
    if (!rows_n[0]) begin
      return 2'd0;
    end else if (!rows_n[1]) begin
      return 2'd1;
    end else if (!rows_n[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  // Keypad legend, row-major.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0:    return 4'h1;
      4'h1:    return 4'h2;
      4'h2:    return 4'h3;
      4'h3:    return 4'hA;
      4'h4:    return 4'h4;
      4'h5:    return 4'h5;
      4'h6:    return 4'h6;
      4'h7:    return 4'hB;
      4'h8:    return 4'h7;
      4'h9:    return 4'h8;
      4'hA:    return 4'h9;
      4'hB:    return 4'hC;
      4'hC:    return 4'hE;
      4'hD:    return 4'h0;
      4'hE:    return 4'hF;
      4'hF:    return 4'hD;
      default: return 4'h0;
    endcase
  endfunction

  logic [SCAN_DIV_W-1:0] cnt;
  logic [1:0]            col;
  logic [1:0]            col_next;
  logic [3:0]            sync_a;
  logic [3:0]            sync_b;
  logic [1:0]            acc_hits;   // switches seen so far this frame, saturates at 2
  logic [3:0]            acc_code;
  res_kind_t             prev_kind;
  logic [3:0]            prev_code;  // 0 unless prev_kind is RES_KEY
  logic [3:0]            stab;
  state_t                state;
  state_t                state_next;

  logic                  sample;
  logic                  frame_end;
  logic [2:0]            col_hits;
  logic [2:0]            hit_sum;
  logic [1:0]            hits_total;
  logic [3:0]            code_total;
  res_kind_t             res_kind;
  logic [3:0]            res_code;
  logic [3:0]            stab_upd;

  logic [3:0]            col_drive;
  logic [3:0]            key_code;
  logic                  strobe;
  logic                  held;
  logic [15:0]           shift_value;
  logic [3:0]            key_next;
  logic                  strobe_next;
  logic                  held_next;
  logic [15:0]           value_next;

  assign kp.cols      = col_drive;
  assign kp.key       = key_code;
  assign kp.key_valid = strobe;
  assign kp.key_held  = held;
  assign kp.value     = shift_value;

  // Fold the current column sample into the frame tally and derive the
  // frame result plus the updated stability count.
  always_comb begin
    sample     = &cnt;
    frame_end  = sample && (col == 2'd3);
    col_next   = sample ? (col + 2'd1) : col;
    col_hits   = hit_count(sync_b);
    hit_sum    = {1'b0, acc_hits} + col_hits;
    hits_total = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    code_total = (acc_hits == 2'd0) ? key_map(first_row(sync_b), col) : acc_code;
    res_kind   = RES_NONE;
    res_code   = 4'h0;
    case (hits_total)
      2'd0: begin
        res_kind = RES_NONE;
        res_code = 4'h0;
      end
      2'd1: begin
        res_kind = RES_KEY;
        res_code = code_total;
      end
      default: begin
        res_kind = RES_MULTI;
        res_code = 4'h0;
      end
    endcase
    if ((res_kind == prev_kind) && (res_code == prev_code)) begin
      stab_upd = (stab == 4'hF) ? 4'hF : (stab + 4'd1);
    end else begin
      stab_upd = 4'd1;
    end
  end

  // Column dwell counter, column index and the registered column drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      col       <= 2'd0;
      col_drive <= 4'b1110;
    end else begin
      cnt       <= cnt + CNT_ONE;
      col       <= col_next;
      col_drive <= ~(4'b0001 << col_next);
    end
  end

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 4'hF;
      sync_b <= 4'hF;
    end else begin
      sync_a <= kp.rows;
      sync_b <= sync_a;
    end
  end

  // Per-frame switch tally; cleared at each frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_hits <= 2'd0;
      acc_code <= 4'h0;
    end else if (frame_end) begin
      acc_hits <= 2'd0;
      acc_code <= 4'h0;
    end else if (sample) begin
      acc_hits <= hits_total;
      acc_code <= code_total;
    end else begin
      acc_hits <= acc_hits;
      acc_code <= acc_code;
    end
  end

  // Previous frame result and its run length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_kind <= RES_NONE;
      prev_code <= 4'h0;
      stab      <= 4'd0;
    end else if (frame_end) begin
      prev_kind <= res_kind;
      prev_code <= res_code;
      stab      <= stab_upd;
    end else begin
      prev_kind <= prev_kind;
      prev_code <= prev_code;
      stab      <= stab;
    end
  end

  // Press/release FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and output values. The stability count only hits DEB once per
  // run, so a long hold or a long release acts exactly once. HELD ignores KEY
  // and MULTI (no repeat, no re-strobe on key change); IDLE ignores MULTI.
  always_comb begin
    state_next  = state;
    key_next    = key_code;
    strobe_next = 1'b0;
    held_next   = held;
    value_next  = shift_value;
    if (frame_end && (stab_upd == DEB)) begin
      case (state)
        IDLE: begin
          if (res_kind == RES_KEY) begin
            state_next  = HELD;
            key_next    = res_code;
            strobe_next = 1'b1;
            held_next   = 1'b1;
            value_next  = {shift_value[11:0], res_code};
          end else begin
            state_next = IDLE;
          end
        end
        HELD: begin
          if (res_kind == RES_NONE) begin
            state_next = IDLE;
            held_next  = 1'b0;
          end else begin
            state_next = HELD;
          end
        end
        default: begin
          state_next = IDLE;
          held_next  = 1'b0;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  // Registered key outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code    <= 4'h0;
      strobe      <= 1'b0;
      held        <= 1'b0;
      shift_value <= 16'h0000;
    end else begin
      key_code    <= key_next;
      strobe      <= strobe_next;
      held        <= held_next;
      shift_value <= value_next;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV_W = 2
// (16-cycle frames) and DEBOUNCE_FRAMES = 3. A keypad model pulls a row low
// when a pressed switch has its column driven low. A frame-level model
// predicts every output on every cycle; literal checks pin key moments.
module tb_keypad_scanner;

  localparam int DEB_FRAMES = 3;
  localparam int FRAME      = 16;

  logic        clk;
  logic        rst;
  logic [15:0] pressed;   // bit r*4+c set = switch (r, c) closed
  logic [3:0]  rows_v;

  int errors;
  int checks;
  int dut_strobes;
  int last_strobe_t;
  int s0;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV_W      (2),
    .DEBOUNCE_FRAMES (DEB_FRAMES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive keypad matrix.
  always_comb begin
    rows_v = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !kif.cols[c]) rows_v[r] = 1'b0;
      end
    end
  end
  assign kif.rows = rows_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int legend(input int idx);
    case (idx)
      0: return 1;   1: return 2;   2: return 3;   3: return 10;
      4: return 4;   5: return 5;   6: return 6;   7: return 11;
      8: return 7;   9: return 8;  10: return 9;  11: return 12;
      12: return 14; 13: return 0;  14: return 15; default: return 13;
    endcase
  endfunction

  // -1 = no switch, 0..15 = the single key's code, 16 = two or more switches.
  function automatic int classify(input logic [15:0] p);
    int n;
    int idx;
    n = 0;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (p[i]) begin
        n++;
        idx = i;
      end
    end
    if (n == 0) return -1;
    if (n == 1) return legend(idx);
    return 16;
  endfunction

  // Frame-level reference model and per-cycle compare.
  int          t;
  int          hist[$];
  bit          m_held;
  logic [3:0]  m_key;
  logic [15:0] m_value;
  bit          m_valid;

  always @(posedge clk) begin
    int          res;
    int          n;
    logic [3:0]  one_hot;
    #1;
    if (rst) begin
      t = 0;
      hist.delete();
      m_held = 0;
      m_key = 4'h0;
      m_value = 16'h0000;
      m_valid = 0;
    end else begin
      t++;
      m_valid = 0;
      if (t % FRAME == 0) begin
        res = classify(pressed);
        hist.push_back(res);
        n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
          if (hist[i] != res) break;
          n++;
        end
        if (n > 15) n = 15;
        if (!m_held && n == DEB_FRAMES && res >= 0 && res < 16) begin
          m_valid = 1;
          m_key = res[3:0];
          m_value = {m_value[11:0], res[3:0]};
          m_held = 1;
        end else if (m_held && n == DEB_FRAMES && res < 0) begin
          m_held = 0;
        end
      end
    end
    one_hot = 4'b0001 << ((t / 4) % 4);
    check("cols", {28'd0, kif.cols}, {28'd0, ~one_hot});
    check("key", {28'd0, kif.key}, {28'd0, m_key});
    check("key_valid", {31'd0, kif.key_valid}, {31'd0, m_valid});
    check("key_held", {31'd0, kif.key_held}, {31'd0, m_held});
    check("value", {16'd0, kif.value}, {16'd0, m_value});
    if (kif.key_valid === 1'b1) begin
      dut_strobes++;
      last_strobe_t = t;
    end
  end

  task automatic frames(input int n);
    repeat (n * FRAME) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    dut_strobes = 0;
    last_strobe_t = -1;
    pressed = 16'h0000;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cols", {28'd0, kif.cols}, 32'h0000000E);
    check("rst_outs", {11'd0, kif.key, kif.key_valid, kif.key_held, kif.value}, 32'h0);
    rst = 1'b0;

    // Idle scanning, no keys.
    frames(10);
    check("scan_no_strobe", dut_strobes, 0);

    // Single press of '6' held from before the first frame.
    rst = 1'b1;
    pressed[1*4+2] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = dut_strobes;
    frames(3);
    check("press_strobes", dut_strobes, s0 + 1);
    check("press_cycle", last_strobe_t, 48);
    check("press_key", {28'd0, kif.key}, 32'h6);
    check("press_value", {16'd0, kif.value}, 32'h0006);
    check("press_held", {31'd0, kif.key_held}, 32'h1);
    frames(5);
    check("no_repeat", dut_strobes, s0 + 1);
    pressed = 16'h0000;
    frames(2);
    check("release_early", {31'd0, kif.key_held}, 32'h1);
    frames(1);
    check("release_done", {31'd0, kif.key_held}, 32'h0);

    // Bounce on '1', then a stable hold.
    s0 = dut_strobes;
    for (int i = 0; i < 4; i++) begin
      pressed[0] = (i % 2 == 0);
      frames(1);
    end
    check("bounce_none", dut_strobes, s0);
    pressed[0] = 1'b1;
    frames(2);
    check("bounce_two_stable", dut_strobes, s0);
    frames(1);
    check("bounce_strobe", dut_strobes, s0 + 1);
    check("bounce_key", {28'd0, kif.key}, 32'h1);
    pressed = 16'h0000;
    frames(3);

    // A two-frame press of '7' is too short.
    s0 = dut_strobes;
    pressed[2*4+0] = 1'b1;
    frames(2);
    pressed = 16'h0000;
    frames(4);
    check("short_press", dut_strobes, s0);
    check("short_key", {28'd0, kif.key}, 32'h1);

    // Sequence 1, 2, 3, A.
    s0 = dut_strobes;
    for (int k = 0; k < 4; k++) begin
      pressed[k] = 1'b1;
      frames(5);
      pressed = 16'h0000;
      frames(5);
    end
    check("seq_strobes", dut_strobes, s0 + 4);
    check("seq_value", {16'd0, kif.value}, 32'h123A);

    // Two keys together from idle, then a key added while held.
    s0 = dut_strobes;
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    frames(5);
    check("multi_idle", dut_strobes, s0);
    pressed = 16'h0000;
    frames(4);
    pressed[0] = 1'b1;
    frames(3);
    check("multi_first", dut_strobes, s0 + 1);
    pressed[3*4+3] = 1'b1;
    frames(5);
    check("multi_add", dut_strobes, s0 + 1);
    check("multi_held", {31'd0, kif.key_held}, 32'h1);
    check("multi_value", {16'd0, kif.value}, 32'h23A1);
    pressed = 16'h0000;
    frames(4);
    check("multi_release", {31'd0, kif.key_held}, 32'h0);

    // Reset while '6' is held, mid-frame.
    pressed[1*4+2] = 1'b1;
    frames(3);
    check("pre_rst_held", {31'd0, kif.key_held}, 32'h1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_cols", {28'd0, kif.cols}, 32'h0000000E);
    check("async_outs", {11'd0, kif.key, kif.key_valid, kif.key_held, kif.value}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = dut_strobes;
    frames(3);
    check("rearm_strobes", dut_strobes, s0 + 1);
    check("rearm_cycle", last_strobe_t, 48);
    check("rearm_key", {28'd0, kif.key}, 32'h6);
    check("rearm_value", {16'd0, kif.value}, 32'h0006);
    pressed = 16'h0000;
    frames(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
